regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32: register data width in bits, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 32: number of registers, a power of 2, at least 2.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, register 0 reads as 0 and is never written or reserved.
REQ-004 SHALL have parameter BYPASS, default 1: when 1, a write in the current cycle is forwarded to the read ports.
REQ-005 SHALL define AW = log2(DEPTH) and BW = WIDTH/8.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port wr_en, input, 1 bit: write strobe.
REQ-009 SHALL have port wr_sel, input, AW bits: write register index.
REQ-010 SHALL have port wr_data, input, WIDTH bits: write data.
REQ-011 SHALL have port wr_be, input, BW bits: byte enables; bit k covers data bits 8k+7..8k.
REQ-012 SHALL have port rsv_en, input, 1 bit: scoreboard reserve strobe.
REQ-013 SHALL have port rsv_sel, input, AW bits: register index to mark busy.
REQ-014 SHALL have ports rd_sel_a and rd_sel_b, input, AW bits each: read indices.
REQ-015 SHALL have ports rd_data_a and rd_data_b, output, WIDTH bits each: read data.
REQ-016 SHALL have ports rd_busy_a and rd_busy_b, output, 1 bit each: the selected register has a write pending.
REQ-017 SHALL have port busy_count, output, AW+1 bits: number of registers currently busy.

Function
REQ-018 SHALL write, at a rising edge with wr_en=1 and rst=0, every byte k of reg[wr_sel] for which wr_be[k]=1; bytes with wr_be[k]=0 SHALL be retained.
REQ-019 SHALL ignore writes to index 0 when ZERO_REG=1.
REQ-020 SHALL drive rd_data_x combinationally from reg[rd_sel_x], with zero latency.
REQ-021 SHALL drive rd_data_x as 0 for rd_sel_x=0 when ZERO_REG=1.
REQ-022 SHALL, when BYPASS=1 and wr_en=1 and wr_sel=rd_sel_x (a legal write target), return on rd_data_x the merge of wr_data bytes where wr_be=1 with stored bytes elsewhere, in the same cycle.
REQ-023 SHALL, when BYPASS=0, return the pre-write value during the write cycle and the new value from the next cycle.
REQ-024 SHALL set busy[rsv_sel] at the edge when rsv_en=1; busy[0] SHALL never be set when ZERO_REG=1.
REQ-025 SHALL clear busy[wr_sel] at the edge when wr_en=1, regardless of wr_be.
REQ-026 SHALL, when the same index is reserved and written in the same cycle, leave busy at 1 (set wins) while still performing the data write.
REQ-027 SHALL, on a write to a register that is not busy, perform the write and leave busy at 0.
REQ-028 SHALL, on rsv_en to an already busy register, keep busy at 1 with no count change.
REQ-029 SHALL drive rd_busy_x = busy[rd_sel_x], masked to 0 when BYPASS=1 and a same-cycle write to rd_sel_x is forwarded.
REQ-030 SHALL keep busy_count as a registered value equal to the population count of busy, updated in the same edge as busy; it SHALL reach DEPTH-ZERO_REG at most without wrap.

Reset
REQ-031 SHALL, at a rising edge with rst=1, clear all registers and all busy bits to 0 and set busy_count to 0.
REQ-032 SHALL give rst priority over wr_en and rsv_en in the same cycle.
REQ-033 SHALL have all outputs derive from cleared state after reset, so rd_data_x and rd_busy_x are 0 except for bypass of a write in the next cycle.
REQ-034 SHALL, when reset is asserted mid-sequence, discard pending reservations.

Structure
REQ-035 SHALL place the default WIDTH, DEPTH, ZERO_REG and BYPASS constants, and a byte-merge function, in the shared package dlx_rf_pkg.
REQ-036 SHALL implement one register row (byte-enabled storage plus its busy bit) as the sub-module rf_row, instantiated DEPTH times.
REQ-037 SHALL implement the read muxes and the bypass in the top level.

Verification
REQ-038 SHALL be verified by: reset, then read all indices -> all 0, busy_count=0.
REQ-039 SHALL be verified by: write r5=0xDEADBEEF with wr_be=4'b1111, then wr_be=4'b0010 with data 0x00001200 -> r5 reads 0xDEAD12EF.
REQ-040 SHALL be verified by: write r0=0xFFFFFFFF and rsv r0 -> rd_data=0, rd_busy=0, busy_count=0.
REQ-041 SHALL be verified by: write r7=0x12345678 while rd_sel_a=7, with BYPASS=1 -> same-cycle rd_data_a=0x12345678; with BYPASS=0 -> old value, then new value on the next cycle.
REQ-042 SHALL be verified by: rsv r3, rsv r4 -> busy_count=2, rd_busy for r3=1; then write r3 and rsv r3 in the same cycle -> busy r3 stays 1, busy_count=2.
REQ-043 SHALL be verified by: reserve 31 registers, assert rst together with wr_en and rsv_en -> all busy=0, registers 0, busy_count=0.

Source files
------------

// File: rtl/dlx_rf_pkg.sv
// Shared constants and the byte-merge helper for the scoreboarded register file.
package dlx_rf_pkg;

   localparam int RF_WIDTH    = 32;
   localparam int RF_DEPTH    = 32;
   localparam int RF_ZERO_REG = 1;
   localparam int RF_BYPASS   = 1;

   // The merge helper works on a fixed maximum width; callers zero-extend their
   // operands and truncate the result back to their own WIDTH.
   localparam int RF_MAX_W = 1024;
   localparam int RF_MAX_B = RF_MAX_W / 8;

   function automatic logic [RF_MAX_W-1:0] byte_merge(
      input logic [RF_MAX_W-1:0] old_val,
      input logic [RF_MAX_W-1:0] new_val,
      input logic [RF_MAX_B-1:0] be
   );
      logic [RF_MAX_W-1:0] merged;
      for (int k = 0; k < RF_MAX_B; k++) begin
         merged[8*k +: 8] = be[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/rf_row.sv
// One register row: byte-enabled storage plus its scoreboard busy bit.
module rf_row
   import dlx_rf_pkg::*;
#(
   parameter int WIDTH     = RF_WIDTH,
   parameter bit HARDWIRED = 1'b0,
   localparam int BW       = WIDTH / 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_hit,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [BW-1:0]    wr_be,
   input  logic             rsv_hit,
   output logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             busy_nxt
);

   // Next busy value: a reservation wins over the clearing write; a hardwired row never goes busy.
   always_comb begin
      busy_nxt = busy;
      if (rsv_hit) begin
         busy_nxt = 1'b1;
      end else if (wr_hit) begin
         busy_nxt = 1'b0;
      end
      if (HARDWIRED) begin
         busy_nxt = 1'b0;
      end
   end

   // Storage and busy update; reset overrides any write or reservation.
   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
         busy <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (wr_hit && !HARDWIRED) begin
            data <= WIDTH'(byte_merge(RF_MAX_W'(data), RF_MAX_W'(wr_data), RF_MAX_B'(wr_be)));
         end
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with a per-register busy scoreboard,
// optional hardwired zero register and optional write-to-read forwarding.
module regfile_sb
   import dlx_rf_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int DEPTH    = RF_DEPTH,
   parameter int ZERO_REG = RF_ZERO_REG,
   parameter int BYPASS   = RF_BYPASS,
   localparam int AW      = $clog2(DEPTH),
   localparam int BW      = WIDTH / 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [BW-1:0]    wr_be,
   input  logic             rsv_en,
   input  logic [AW-1:0]    rsv_sel,
   input  logic [AW-1:0]    rd_sel_a,
   input  logic [AW-1:0]    rd_sel_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_busy_a,
   output logic             rd_busy_b,
   output logic [AW:0]      busy_count
);

   logic [WIDTH-1:0] row_data [DEPTH];
   logic [DEPTH-1:0] busy_vec;
   logic [DEPTH-1:0] busy_nxt_vec;
   logic [AW:0]      count_nxt;
   logic             legal_wr;
   logic             fwd_a;
   logic             fwd_b;
   logic [WIDTH-1:0] wr_merge;

   for (genvar i = 0; i < DEPTH; i++) begin : g_row
      logic wr_hit;
      logic rsv_hit;
      assign wr_hit  = wr_en  && (wr_sel  == AW'(i));
      assign rsv_hit = rsv_en && (rsv_sel == AW'(i));

      rf_row #(
         .WIDTH     (WIDTH),
         .HARDWIRED ((ZERO_REG != 0) && (i == 0))
      ) u_row (
         .clk      (clk),
         .rst      (rst),
         .wr_hit   (wr_hit),
         .wr_data  (wr_data),
         .wr_be    (wr_be),
         .rsv_hit  (rsv_hit),
         .data     (row_data[i]),
         .busy     (busy_vec[i]),
         .busy_nxt (busy_nxt_vec[i])
      );
   end

   // Read muxes with same-cycle forwarding of a write to a real (non-hardwired) register.
   always_comb begin
      legal_wr  = wr_en && !((ZERO_REG != 0) && (wr_sel == '0));
      fwd_a     = (BYPASS != 0) && legal_wr && (wr_sel == rd_sel_a);
      fwd_b     = (BYPASS != 0) && legal_wr && (wr_sel == rd_sel_b);
      wr_merge  = WIDTH'(byte_merge(RF_MAX_W'(row_data[wr_sel]), RF_MAX_W'(wr_data),
                                    RF_MAX_B'(wr_be)));
      rd_data_a = fwd_a ? wr_merge : row_data[rd_sel_a];
      rd_data_b = fwd_b ? wr_merge : row_data[rd_sel_b];
      rd_busy_a = busy_vec[rd_sel_a] & ~fwd_a;
      rd_busy_b = busy_vec[rd_sel_b] & ~fwd_b;
   end

   // Population count of the busy bits as they will be after this edge.
   always_comb begin
      count_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_nxt = count_nxt + (AW+1)'(busy_nxt_vec[i]);
      end
   end

   // Registered busy count, updated on the same edge as the busy bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_count <= '0;
      end else begin
         busy_count <= count_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: one forwarding and one non-forwarding instance share the
// same stimulus and are compared against an array-based reference model.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_sel;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rsv_en;
   logic [4:0]  rsv_sel;
   logic [4:0]  rd_sel_a;
   logic [4:0]  rd_sel_b;

   logic [31:0] rd_data_a,  rd_data_b,  nb_data_a,  nb_data_b;
   logic        rd_busy_a,  rd_busy_b,  nb_busy_a,  nb_busy_b;
   logic [5:0]  busy_count, nb_busy_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_regs [32];
   bit          m_busy [32];

   always #5 clk = ~clk;

   regfile_sb #(.BYPASS(1)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .wr_be(wr_be), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
      .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b), .busy_count(busy_count)
   );

   regfile_sb #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .wr_be(wr_be), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
      .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
      .rd_data_a(nb_data_a), .rd_data_b(nb_data_b),
      .rd_busy_a(nb_busy_a), .rd_busy_b(nb_busy_b), .busy_count(nb_busy_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] be);
      logic [31:0] r;
      r = old_v;
      for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
      return r;
   endfunction

   function automatic int model_count();
      int c;
      c = 0;
      for (int i = 0; i < 32; i++) if (m_busy[i]) c++;
      return c;
   endfunction

   task automatic drive(input bit r, input bit we, input int ws, input logic [31:0] wd,
                        input logic [3:0] be, input bit re, input int rs,
                        input int ra, input int rb);
      rst = r; wr_en = we; wr_sel = 5'(ws); wr_data = wd; wr_be = be;
      rsv_en = re; rsv_sel = 5'(rs); rd_sel_a = 5'(ra); rd_sel_b = 5'(rb);
   endtask

   // Expected combinational outputs for one read index under the current inputs.
   task automatic check_port(input string p, input int idx, input logic [31:0] d_byp,
                             input logic b_byp, input logic [31:0] d_nb, input logic b_nb);
      bit          fwd;
      logic [31:0] stored;
      fwd    = wr_en && (wr_sel != 0) && (int'(wr_sel) == idx);
      stored = (idx == 0) ? 32'h0 : m_regs[idx];
      chk({"data_byp_", p}, d_byp, fwd ? merge_bytes(stored, wr_data, wr_be) : stored);
      chk({"busy_byp_", p}, 32'(b_byp), 32'(fwd ? 1'b0 : m_busy[idx]));
      chk({"data_nb_", p}, d_nb, stored);
      chk({"busy_nb_", p}, 32'(b_nb), 32'(m_busy[idx]));
   endtask

   task automatic check_all();
      #1;
      check_port("a", int'(rd_sel_a), rd_data_a, rd_busy_a, nb_data_a, nb_busy_a);
      check_port("b", int'(rd_sel_b), rd_data_b, rd_busy_b, nb_data_b, nb_busy_b);
      chk("busy_count", 32'(busy_count), 32'(model_count()));
      chk("busy_count_nb", 32'(nb_busy_count), 32'(model_count()));
   endtask

   // Advance one clock and apply the architectural effect of the inputs to the model.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 0;
         end
      end else begin
         if (wr_en && wr_sel != 0) m_regs[wr_sel] = merge_bytes(m_regs[wr_sel], wr_data, wr_be);
         if (wr_en) m_busy[wr_sel] = 0;
         if (rsv_en && rsv_sel != 0) m_busy[rsv_sel] = 1;
      end
      #1;
   endtask

   task automatic cyc(input bit r, input bit we, input int ws, input logic [31:0] wd,
                      input logic [3:0] be, input bit re, input int rs,
                      input int ra, input int rb);
      drive(r, we, ws, wd, be, re, rs, ra, rb);
      check_all();
      step();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 32'h0;
         m_busy[i] = 0;
      end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();

      // After reset every register reads 0 and nothing is busy.
      for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 0, 0, 0, i, 31 - i);
      chk("reset_count", 32'(busy_count), 32'd0);

      // Byte-enabled partial write.
      cyc(0, 1, 5, 32'hDEADBEEF, 4'b1111, 0, 0, 5, 0);
      cyc(0, 1, 5, 32'h00001200, 4'b0010, 0, 0, 1, 2);
      drive(0, 0, 0, 0, 0, 0, 0, 5, 5);
      #1;
      chk("r5_partial", rd_data_a, 32'hDEAD12EF);
      step();

      // Register 0 is hardwired: no write, no reservation.
      cyc(0, 1, 0, 32'hFFFFFFFF, 4'b1111, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("r0_data", rd_data_a, 32'h0);
      chk("r0_busy", 32'(rd_busy_a), 32'd0);
      chk("r0_count", 32'(busy_count), 32'd0);
      step();

      // Forwarding vs. non-forwarding read of r7 during its write.
      drive(0, 1, 7, 32'h12345678, 4'b1111, 0, 0, 7, 0);
      #1;
      chk("r7_byp_same", rd_data_a, 32'h12345678);
      chk("r7_nb_same", nb_data_a, 32'h0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 7, 7);
      #1;
      chk("r7_nb_next", nb_data_a, 32'h12345678);
      step();

      // Scoreboard: two reservations, then write+reserve of the same index.
      cyc(0, 0, 0, 0, 0, 1, 3, 3, 4);
      cyc(0, 0, 0, 0, 0, 1, 4, 3, 4);
      drive(0, 0, 0, 0, 0, 0, 0, 3, 4);
      #1;
      chk("rsv_count2", 32'(busy_count), 32'd2);
      chk("rsv_busy_r3", 32'(rd_busy_a), 32'd1);
      step();
      cyc(0, 1, 3, 32'hA5A5A5A5, 4'b1111, 1, 3, 3, 4);
      drive(0, 0, 0, 0, 0, 0, 0, 3, 4);
      #1;
      chk("setwins_busy", 32'(rd_busy_a), 32'd1);
      chk("setwins_count", 32'(busy_count), 32'd2);
      chk("setwins_data", rd_data_a, 32'hA5A5A5A5);
      step();
      cyc(0, 0, 0, 0, 0, 1, 4, 4, 3);

      // Fill the scoreboard, then reset with competing write and reserve.
      for (int i = 1; i < 32; i++) cyc(0, 0, 0, 0, 0, 1, i, i, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 31);
      #1;
      chk("full_count", 32'(busy_count), 32'd31);
      step();
      cyc(1, 1, 9, 32'hCAFEF00D, 4'b1111, 1, 9, 9, 5);
      drive(0, 0, 0, 0, 0, 0, 0, 9, 5);
      #1;
      chk("rst_count", 32'(busy_count), 32'd0);
      chk("rst_r9", rd_data_a, 32'h0);
      chk("rst_r5", rd_data_b, 32'h0);
      step();
      for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 0, 0, 0, i, (i + 7) % 32);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 1500; n++) begin
         int ws;
         int ra;
         int rb;
         ws = int'($urandom_range(0, 31));
         ra = ($urandom_range(0, 2) == 0) ? ws : int'($urandom_range(0, 31));
         rb = ($urandom_range(0, 2) == 0) ? ws : int'($urandom_range(0, 31));
         cyc(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), ws, $urandom,
             4'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0),
             int'($urandom_range(0, 31)), ra, rb);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
